// File: rtl/bf16_mul_driver.sv
// bf16_mul_driver: burst stimulus and response engine for the BF16 multiplier datapath.
//
// Generates pseudo-random operand pairs from a 32-bit LFSR, presents them on a
// valid/ready stream towards the multiplier, and absorbs the products coming
// back while folding them into a 16-bit rotate-xor signature.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start, len, seed     burst request (sampled only while idle)
//   m_valid, m_ready     operand stream handshake (driver -> multiplier)
//   m_a, m_b             operand pair = lfsr[31:16], lfsr[15:0]
//   s_valid, s_ready     product stream handshake (multiplier -> driver)
//   s_p                  product
//   busy, done           burst in progress / one-cycle end-of-burst pulse
//   signature            rolling product signature
//   result_count         products accepted in the current or last burst
//   err_extra            sticky: a product arrived with no outstanding request

module bf16_mul_driver #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic [31:0]        seed,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [15:0]        m_a,
    output logic [15:0]        m_b,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [15:0]        s_p,
    output logic               busy,
    output logic               done,
    output logic [15:0]        signature,
    output logic [COUNT_W-1:0] result_count,
    output logic               err_extra
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [31:0] LfsrTaps = 32'h8020_0003;

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [COUNT_W-1:0] issued_q, issued_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic [COUNT_W-1:0] result_count_q, result_count_d;
    logic [15:0]        signature_q, signature_d;
    logic               err_extra_q, err_extra_d;
    logic               s_ready_q;

    logic accept;
    logic issue_hs;

    assign accept   = s_valid & s_ready_q;
    assign issue_hs = (state_q == StIssue) & m_ready;

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        issued_d       = issued_q;
        len_d          = len_q;
        result_count_d = result_count_q;
        signature_d    = signature_q;
        err_extra_d    = err_extra_q;

        // Product acceptance runs independently of the issue side; the error
        // check deliberately uses the pre-update issued count.
        if (accept) begin
            signature_d = {signature_q[14:0], signature_q[15]} ^ s_p;
            if (result_count_q != {COUNT_W{1'b1}}) begin
                result_count_d = result_count_q + COUNT_W'(1);
            end
            if (state_q == StIdle || state_q == StDone || result_count_q >= issued_q) begin
                err_extra_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A fresh burst overrides anything the product side did this cycle.
                    len_d          = len;
                    issued_d       = '0;
                    result_count_d = '0;
                    signature_d    = '0;
                    err_extra_d    = 1'b0;
                    if (len == '0) begin
                        state_d = StDone;
                    end else begin
                        lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (issue_hs) begin
                    issued_d = issued_q + COUNT_W'(1);
                    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
                    if (issued_q + COUNT_W'(1) == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (result_count_q >= len_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= StIdle;
            lfsr_q         <= '0;
            issued_q       <= '0;
            len_q          <= '0;
            result_count_q <= '0;
            signature_q    <= '0;
            err_extra_q    <= 1'b0;
            s_ready_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            issued_q       <= issued_d;
            len_q          <= len_d;
            result_count_q <= result_count_d;
            signature_q    <= signature_d;
            err_extra_q    <= err_extra_d;
            s_ready_q      <= 1'b1;
        end
    end

    assign m_valid      = (state_q == StIssue);
    assign m_a          = lfsr_q[31:16];
    assign m_b          = lfsr_q[15:0];
    assign s_ready      = s_ready_q;
    assign busy         = (state_q == StIssue) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign signature    = signature_q;
    assign result_count = result_count_q;
    assign err_extra    = err_extra_q;

endmodule

// File: doc/bf16_mul_driver.md
# bf16_mul_driver

Burst stimulus and response engine for the BF16 multiplier datapath. It sits on the other side of the multiplier's valid/ready streams: it generates pseudo-random operand pairs, drives them into the multiplier's input port, and consumes products from the multiplier's output port. A 16-bit rolling signature of the products is accumulated so a burst can be checked against a golden value. Top level: `start` → driver → `bf16_mul` → driver → `signature`/`done`.

## Interface
- `COUNT_W`, 16: width of the burst length and of the result counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `len`  in  COUNT_W  number of operand pairs in the burst; sampled with `start`.
- `seed`  in  32  LFSR seed; sampled with `start`. A value of 0 is replaced by 1.
- `m_valid`  out  1  operand pair valid; connects to multiplier `i_valid`.
- `m_ready`  in  1  multiplier accepts operands; from multiplier `i_ready`.
- `m_a`  out  16  operand A = `lfsr[31:16]`.
- `m_b`  out  16  operand B = `lfsr[15:0]`.
- `s_valid`  in  1  product valid; from multiplier `o_valid`.
- `s_ready`  out  1  driver accepts a product; connects to multiplier `o_ready`.
- `s_p`  in  16  product.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle pulse at the end of a burst.
- `signature`  out  16  rolling product signature; held until the next `start`.
- `result_count`  out  COUNT_W  number of products accepted in the current or last burst.
- `err_extra`  out  1  sticky flag: a product was accepted with no outstanding request. Cleared by reset or `start`.

## Operation
- **States:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start` with `len != 0`: load `lfsr` from `seed` (0 maps to 1), clear `issued`, `result_count`, `signature` and `err_extra`, then go to ISSUE.
  - `start` with `len == 0`: clear the same registers, then go to DONE.
- **ISSUE**
  - `m_valid = 1`.
  - On a handshake (`m_valid & m_ready`): `issued++`, and the LFSR advances.
  - LFSR step: if `lfsr[0]` then `lfsr = (lfsr >> 1) ^ 32'h80200003`, else `lfsr = lfsr >> 1`.
  - When the handshake that makes `issued == len` occurs, go to DRAIN.
- **DRAIN**
  - `m_valid = 0`.
  - Go to DONE on the cycle after `result_count` reaches `len`.
- **DONE**
  - `done = 1` for exactly one cycle, then go to IDLE.
- **Operand stability:** while `m_valid = 1` and `m_ready = 0`, `m_a` and `m_b` must not change.
- **Product acceptance:**
  - `s_ready = 1` in every state once out of reset.
  - Each accepted product (`s_valid & s_ready`): `signature = {signature[14:0], signature[15]} ^ s_p`, and `result_count++`, saturating at all ones.
- **Error flag:** accepting a product when `result_count >= issued`, or in IDLE/DONE, sets `err_extra`. The signature is still updated in that case.
- **Start while busy:** `start` in ISSUE, DRAIN or DONE is ignored; `len` and `seed` are not resampled.
- **Simultaneous events:**
  - An issue handshake and a product acceptance in the same cycle both take effect.
  - The comparison that sets `err_extra` uses the pre-update `issued` value.
- **Reset mid-burst:** `rstn = 0` on any edge forces all outputs to their reset values and the state to IDLE. The burst is abandoned and no `done` is produced.

## Timing
- **Reset values:**
  - `m_valid`, `s_ready`, `busy`, `done`, `err_extra` = 0.
  - `m_a`, `m_b` = 16'h0000 (LFSR resets to 32'h0).
  - `signature` = 0, `result_count` = 0.
- **Ready after reset:** `s_ready` rises on the first edge with `rstn = 1`.
- **Issue latency:** `start` sampled at edge N gives `m_valid = 1` and `busy = 1` after edge N.
- **Throughput:** one operand pair per cycle while `m_ready = 1`. `m_a`/`m_b` update on the same edge as the handshake.
- **Completion latency:** last product accepted at edge K → DONE after K+1 → `done = 1` in cycle K+1..K+2 → IDLE after K+2.
- **Zero-length burst:** `start` with `len = 0` at edge N gives `done = 1` in the cycle after N, with `busy = 0` throughout.
- **Output stability:** `signature` and `result_count` are stable from `done` until the next accepted `start`.

## Test plan
- **Seed sequence:** `seed` = 32'h1, `len` = 2, `m_ready` = 1 → pairs (16'h0000, 16'h0001) then (16'h8020, 16'h0003); `m_valid` falls after the second handshake.
- **Backpressure:** `m_ready` low for 5 cycles with `m_valid` high → `m_a`/`m_b` stay constant; `issued` does not advance.
- **Signature:** `len` = 2, products 16'h8000 then 16'h0001 → `signature` = 16'h8000, then 16'h0000; `result_count` = 2; one `done` pulse.
- **Zero length and zero seed:**
  - `len` = 0 → `done` one cycle after `start`, no `m_valid`.
  - `seed` = 0, `len` = 1 → first pair (16'h0000, 16'h0001).
- **Stray product:** `s_valid` pulse while IDLE → `err_extra` = 1; the next `start` clears it.
- **Mid-burst reset and start while busy:**
  - `rstn` low during ISSUE with `len` = 100 → all outputs at reset values after the edge; no `done`.
  - `start` asserted during DRAIN → ignored.
